// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (in clk cycles) of an asynchronous PWM input
// once per rising-edge period, with a watchdog that flags a stuck 0 %/100 % input.
module pwm_capture #(
   parameter int unsigned CNT_W       = 10,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             stuck,
   output logic             level
);

   typedef enum logic [0:0] {StIdle, StMeasure} state_e;

   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_prev_q;
   logic                   rise_q;

   state_e                 state_q;
   logic [CNT_W-1:0]       per_cnt_q;
   logic [CNT_W-1:0]       hi_cnt_q;
   logic [CNT_W-1:0]       idle_cnt_q;
   logic [CNT_W-1:0]       high_time_q;
   logic [CNT_W-1:0]       period_q;
   logic                   valid_q;
   logic                   stuck_q;

   assign s = sync_q[SYNC_STAGES-1];

   // Edge detect is registered, so s_prev_q is the level aligned with rise_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         s_prev_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_prev_q <= s;
         rise_q   <= s & ~s_prev_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         idle_cnt_q  <= '0;
         high_time_q <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               per_cnt_q <= '0;
               hi_cnt_q  <= '0;
               if (rise_q) begin
                  // First rise only arms the measurement.
                  per_cnt_q  <= CntOne;
                  hi_cnt_q   <= CntOne;
                  idle_cnt_q <= '0;
                  state_q    <= StMeasure;
               end else if (!stuck_q) begin
                  // Only reachable after reset; a timeout from MEASURE arrives already stuck.
                  if (idle_cnt_q == TimeoutCnt) begin
                     stuck_q     <= 1'b1;
                     period_q    <= '0;
                     high_time_q <= s_prev_q ? '1 : '0;
                     valid_q     <= 1'b1;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + CntOne;
                  end
               end
            end
            StMeasure: begin
               if (rise_q) begin
                  high_time_q <= hi_cnt_q;
                  period_q    <= per_cnt_q;
                  stuck_q     <= 1'b0;
                  valid_q     <= 1'b1;
                  per_cnt_q   <= CntOne;
                  hi_cnt_q    <= CntOne;
               end else if (per_cnt_q == TimeoutCnt) begin
                  stuck_q     <= 1'b1;
                  period_q    <= '0;
                  high_time_q <= s_prev_q ? '1 : '0;
                  valid_q     <= 1'b1;
                  per_cnt_q   <= '0;
                  hi_cnt_q    <= '0;
                  state_q     <= StIdle;
               end else begin
                  per_cnt_q <= per_cnt_q + CntOne;
                  hi_cnt_q  <= hi_cnt_q + CNT_W'(s_prev_q);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign high_time = high_time_q;
   assign period    = period_q;
   assign valid     = valid_q;
   assign stuck     = stuck_q;
   assign level     = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven PWM patterns, randomized segment streams
// against a period-list model, and hand sequences for stuck, reset and latency corners.
module tb_pwm_capture;

   localparam int CNT_W   = 10;
   localparam int SYNC    = 2;
   localparam int TIMEOUT = 1023;
   localparam int ALL1    = (1 << CNT_W) - 1;

   typedef struct {
      int hi;
      int lo;
   } seg_t;

   typedef struct {
      int ht;
      int per;
      int stk;
   } rep_t;

   typedef struct {
      int hi;
      int lo;
      int reps;
      int exp_ht;
      int exp_per;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] high_time;
   logic [CNT_W-1:0] period;
   logic             valid;
   logic             stuck;
   logic             level;

   int   checks = 0;
   int   errors = 0;
   seg_t segs[$];
   rep_t obs[$];
   rep_t exp_q[$];
   vec_t vecs[4];

   pwm_capture #(
      .CNT_W(CNT_W),
      .SYNC_STAGES(SYNC),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pwm_in(pwm_in),
      .high_time(high_time),
      .period(period),
      .valid(valid),
      .stuck(stuck),
      .level(level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         rep_t r;
         r.ht  = int'(high_time);
         r.per = int'(period);
         r.stk = int'(stuck);
         obs.push_back(r);
      end
   end

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      obs.delete();
   endtask

   task automatic drive_segs(input int lead);
      hold(1'b0, lead);
      foreach (segs[i]) begin
         hold(1'b1, segs[i].hi);
         hold(1'b0, segs[i].lo);
      end
   endtask

   // Every rise after the first closes one period: report = (high, high+low) of the prior segment.
   task automatic build_expected();
      exp_q.delete();
      for (int i = 0; i + 1 < segs.size(); i++) begin
         rep_t r;
         r.ht  = segs[i].hi;
         r.per = segs[i].hi + segs[i].lo;
         r.stk = 0;
         exp_q.push_back(r);
      end
   endtask

   task automatic compare_reports(input string name);
      int n;
      chk({name, "_count"}, obs.size(), exp_q.size());
      n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_ht[%0d]", name, i), obs[i].ht, exp_q[i].ht);
         chk($sformatf("%s_per[%0d]", name, i), obs[i].per, exp_q[i].per);
         chk($sformatf("%s_stuck[%0d]", name, i), obs[i].stk, exp_q[i].stk);
      end
   endtask

   task automatic push_seg(input int hi, input int lo);
      seg_t s;
      s.hi = hi;
      s.lo = lo;
      segs.push_back(s);
   endtask

   initial begin
      int cyc;

      vecs[0] = '{hi: 128, lo: 384, reps: 3, exp_ht: 128, exp_per: 512};
      vecs[1] = '{hi: 1,   lo: 511, reps: 2, exp_ht: 1,   exp_per: 512};
      vecs[2] = '{hi: 255, lo: 257, reps: 2, exp_ht: 255, exp_per: 512};
      vecs[3] = '{hi: 511, lo: 1,   reps: 2, exp_ht: 511, exp_per: 512};

      // Reset state while rst_n is held low with the input high.
      pwm_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_high_time", int'(high_time), 0);
      chk("rst_period", int'(period), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_stuck", int'(stuck), 0);
      chk("rst_level", int'(level), 0);

      // Table-driven fixed-duty patterns from a 9-bit generator.
      foreach (vecs[v]) begin
         do_reset();
         segs.delete();
         for (int i = 0; i < vecs[v].reps; i++) push_seg(vecs[v].hi, vecs[v].lo);
         push_seg(1, 6);
         drive_segs(3);
         chk($sformatf("vec%0d_count", v), obs.size(), vecs[v].reps);
         foreach (obs[i]) begin
            chk($sformatf("vec%0d_ht[%0d]", v, i), obs[i].ht, vecs[v].exp_ht);
            chk($sformatf("vec%0d_per[%0d]", v, i), obs[i].per, vecs[v].exp_per);
            chk($sformatf("vec%0d_stuck[%0d]", v, i), obs[i].stk, 0);
         end
      end

      // Period/duty switch: the boundary period belongs entirely to the old pattern.
      do_reset();
      segs.delete();
      repeat (4) push_seg(3, 7);
      repeat (4) push_seg(6, 1);
      push_seg(1, 6);
      build_expected();
      drive_segs(3);
      compare_reports("switch");

      // Randomized segment streams.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         segs.delete();
         for (int i = 0; i < 20; i++) push_seg($urandom_range(1, 40), $urandom_range(1, 40));
         push_seg(1, 6);
         build_expected();
         drive_segs(3);
         compare_reports($sformatf("rand%0d", r));
      end

      // Input held low from reset: one stuck report, then silence.
      do_reset();
      pwm_in = 1'b0;
      cyc = 0;
      while (valid !== 1'b1 && cyc < TIMEOUT + 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("low_timeout_seen", int'(valid === 1'b1), 1);
      chk("low_timeout_near", int'(cyc >= TIMEOUT - 2 && cyc <= TIMEOUT + 4), 1);
      chk("low_stuck", int'(stuck), 1);
      chk("low_period", int'(period), 0);
      chk("low_high_time", int'(high_time), 0);
      hold(1'b0, 3 * TIMEOUT);
      chk("low_single_strobe", obs.size(), 1);

      // Input held high after one rise: stuck report with all-ones high time, then restart.
      do_reset();
      hold(1'b0, 2);
      hold(1'b1, TIMEOUT + 20);
      exp_q.delete();
      exp_q.push_back('{ht: ALL1, per: 0, stk: 1});
      compare_reports("high_stuck");
      chk("high_level", int'(level), 1);
      chk("high_stuck_out", int'(stuck), 1);
      obs.delete();
      segs.delete();
      repeat (3) push_seg(10, 10);
      push_seg(1, 6);
      build_expected();
      drive_segs(5);
      compare_reports("restart");
      chk("restart_stuck_out", int'(stuck), 0);

      // Reset asserted mid-period for one cycle, then latency of the first report.
      do_reset();
      segs.delete();
      repeat (3) push_seg(4, 6);
      push_seg(1, 6);
      build_expected();
      drive_segs(3);
      compare_reports("pre_reset");
      hold(1'b1, 2);
      rst_n = 1'b0;
      #1;
      chk("midrst_high_time", int'(high_time), 0);
      chk("midrst_period", int'(period), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_stuck", int'(stuck), 0);
      chk("midrst_level", int'(level), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      obs.delete();
      hold(1'b1, 3);
      hold(1'b0, 4);
      chk("midrst_armed_only", obs.size(), 0);
      pwm_in = 1'b1;
      for (int k = 1; k <= SYNC + 1; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("lat_quiet_edge%0d", k), int'(valid), 0);
      end
      @(posedge clk);
      #1;
      chk("lat_valid", int'(valid), 1);
      chk("lat_period", int'(period), 7);
      chk("lat_high_time", int'(high_time), 3);
      @(posedge clk);
      #1;
      chk("lat_one_cycle", int'(valid), 0);
      chk("midrst_reports", obs.size(), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
